// File: rtl/multicycle_add_sequencer.sv
// WIDTH-bit add/subtract built from one shared CHUNK-bit ripple-carry slice,
// stepped over WIDTH/CHUNK beats with the inter-slice carry held in a flop.
module multicycle_add_sequencer #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NBEATS = WIDTH / CHUNK;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  int unsigned        base;
  logic [CHUNK-1:0]   slice_a, slice_b, slice_s;
  logic               slice_c;

  // The single shared adder slice, steered by the beat counter.
  always_comb begin
    base    = int'(beat_q) * CHUNK;
    slice_a = opa_q[base +: CHUNK];
    slice_b = opb_q[base +: CHUNK];
    {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + (CHUNK+1)'(carry_q);
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    beat_d  = beat_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = slice_s;
        carry_d              = slice_c;
        if (beat_q == LAST_BEAT) begin
          cout_d  = slice_c;
          state_d = DONE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      beat_q  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      beat_q  <= beat_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // NOTE: operand registers are rewritten on every accept before being read,
  // so they carry no reset and stay plain enable flops.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_multicycle_add_sequencer.sv
// Scoreboard bench for multicycle_add_sequencer: a 32-bit-chunk instance for
// the main scenarios and a 16-bit-chunk instance for the four-beat case.
module tb_multicycle_add_sequencer;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a, b;
  logic        cin, sub;

  logic        in_valid, in_ready, out_valid, out_ready, cout, busy;
  logic [63:0] sum;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, cout16, busy16;
  logic [63:0] sum16;

  exp_t exp_q[$];
  exp_t exp16_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_add_sequencer #(.WIDTH(64), .CHUNK(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  multicycle_add_sequencer #(.WIDTH(64), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .busy(busy16)
  );

  function automatic exp_t model(input logic [63:0] av, bv, input logic cv, sv);
    logic [64:0] r;
    exp_t        e;
    if (sv) r = {1'b0, av} - {1'b0, bv} + 65'h1_0000_0000_0000_0000;
    else    r = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
    e.sum  = r[63:0];
    e.cout = r[64];
    return e;
  endfunction

  task automatic drive_accept(input bit use16, input logic [63:0] av, bv,
                              input logic cv, sv);
    int waited = 0;
    while (!(use16 ? in_ready16 : in_ready) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (!(use16 ? in_ready16 : in_ready)) begin
      n_fail++;
      $display("FAIL accept_wait: in_ready=0 after %0d cycles, required 1", waited);
      return;
    end
    a = av; b = bv; cin = cv; sub = sv;
    if (use16) in_valid16 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    if (use16) exp16_q.push_back(model(av, bv, cv, sv));
    else       exp_q.push_back(model(av, bv, cv, sv));
    #1;
    in_valid = 1'b0; in_valid16 = 1'b0;
  endtask

  // Waits for out_valid while scrambling inputs the DUT must ignore.
  task automatic wait_valid(input bit use16, input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (use16) begin
        in_valid16 = 1'($urandom_range(0, 1)); out_ready16 = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      end
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (use16 ? out_valid16 : out_valid) begin
        edges = i;
        break;
      end
    end
    in_valid = 1'b0; in_valid16 = 1'b0; out_ready = 1'b0; out_ready16 = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [63:0] av, bv,
                       input logic cv, sv);
    exp_t e;
    int   edges;
    drive_accept(1'b0, av, bv, cv, sv);
    wait_valid(1'b0, 10, edges);
    n_checks++;
    if (edges != 2) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d edges, required 2", name, edges);
      return;
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: result with empty queue, required one entry", name);
      return;
    end
    e = exp_q.pop_front();
    if (sum !== e.sum || cout !== e.cout) begin
      n_fail++;
      $display("FAIL %s_result: sum=%h cout=%b, required sum=%h cout=%b",
               name, sum, cout, e.sum, e.cout);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_handshake: out_valid=%b in_ready=%b, required 0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== 64'd0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, required 1/0/0/0/0",
               in_ready, out_valid, busy, sum, cout);
    end
    n_checks++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || busy16 !== 1'b0 ||
        sum16 !== 64'd0 || cout16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state16: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, required 1/0/0/0/0",
               in_ready16, out_valid16, busy16, sum16, cout16);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_wrap;
    do_op("t1_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    do_op("t2_chunk_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    do_op("cin_in", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
  endtask

  task automatic test_subtract;
    do_op("t3_sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1);
    do_op("t3_sub_cin_ignored", 64'd7, 64'd5, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   edges;
    drive_accept(1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b1, 1'b0);
    wait_valid(1'b0, 10, edges);
    n_checks++;
    if (edges != 2 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL t4_first_valid: edges=%0d queue=%0d, required 2/1", edges, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.sum || cout !== e.cout) begin
        n_fail++;
        $display("FAIL t4_hold%0d: out_valid=%b in_ready=%b sum=%h cout=%b, required 1/0 sum=%h cout=%b",
                 k, out_valid, in_ready, sum, cout, e.sum, e.cout);
      end
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
    do_op("t4_back_to_back", 64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    drive_accept(1'b0, 64'd3, 64'd4, 1'b0, 1'b0);
    @(posedge clk); #2;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_busy_before: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum !== 64'd0 || cout !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_async_reset: out_valid=%b sum=%h cout=%b in_ready=%b busy=%b, required 0/0/0/1/0",
               out_valid, sum, cout, in_ready, busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op("t5_recover", 64'd3, 64'd4, 1'b0, 1'b0);
  endtask

  task automatic test_chunk16;
    exp_t e;
    int   edges;
    drive_accept(1'b1, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_valid(1'b1, 12, edges);
    n_checks++;
    if (edges != 4) begin
      n_fail++;
      $display("FAIL t6_latency: got %0d edges, required 4", edges);
      return;
    end
    n_checks++;
    if (exp16_q.size() == 0) begin
      n_fail++;
      $display("FAIL t6_scoreboard: result with empty queue, required one entry");
      return;
    end
    e = exp16_q.pop_front();
    if (sum16 !== e.sum || cout16 !== e.cout) begin
      n_fail++;
      $display("FAIL t6_result: sum=%h cout=%b, required sum=%h cout=%b",
               sum16, cout16, e.sum, e.cout);
    end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    n_checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_handshake: out_valid=%b in_ready=%b, required 0/1",
               out_valid16, in_ready16);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      do_op($sformatf("rand%0d", i), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_carry_wrap();
    test_subtract();
    test_back_to_back();
    test_reset_mid_run();
    test_chunk16();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
